voice_scheduler: RTL and testbench
==================================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 8: number of polyphonic voices; power of two, 2..16.
REQ-002 Parameter PHASE_W, default 24: phase accumulator width; matches the 24-bit frequency-step table output.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 sample_tick  in  1  one-cycle strobe at the 44.1 kHz sample rate.
REQ-006 note_valid / note_ready  in / out  1 / 1  note-event handshake; an event is accepted on a cycle where both are high.
REQ-007 note_on  in  1  1 = note-on, 0 = note-off.
REQ-008 note_idx  in  7  MIDI note number 0..127.
REQ-009 tbl_idx  out  7  note index driven to the external combinational frequency-step table.
REQ-010 tbl_step  in  PHASE_W  step returned by the table for tbl_idx, valid in the same cycle.
REQ-011 phase_valid  out  1  one-cycle strobe marking phase_voice/phase_out valid.
REQ-012 phase_voice  out  clog2(NUM_VOICES)  voice number of the emitted phase.
REQ-013 phase_out  out  PHASE_W  updated phase of that voice.
REQ-014 frame_done  out  1  one-cycle pulse after each complete voice scan.
REQ-015 voice_active  out  NUM_VOICES  per-voice busy flags.
REQ-016 overrun  out  1  sticky flag: a sample_tick was lost.

Function
REQ-017 FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on sample_tick or pending-tick flag.
- SCAN -> DONE after voice NUM_VOICES-1.
- DONE -> IDLE after one cycle.
REQ-018 SCAN takes one cycle per voice in ascending order from voice 0, with tbl_idx = note[v].
- Active voice: phase[v] <= phase[v] + tbl_step, modulo 2^PHASE_W (carry discarded).
- Inactive voice: phase[v] unchanged.
REQ-019 phase_valid pulses exactly one cycle after the SCAN cycle of each active voice, carrying that voice number and its new phase; inactive voices emit nothing.
REQ-020 frame_done is high for the single DONE cycle; scan latency from sample_tick to frame_done is NUM_VOICES+1 cycles.
REQ-021 Tick handling while state is not IDLE:
- sample_tick sets the pending flag.
- sample_tick while pending is already set sets overrun; overrun clears only on rst.
REQ-022 note_ready = (state == IDLE) and not sample_tick and not pending; ticks have priority over note events in the same cycle.
REQ-023 Accepted note-on, applied at the accepting edge; state stays IDLE.
- Note already active on a voice: retrigger that voice, phase <= 0.
- Otherwise: lowest-numbered free voice gets note[v] <= note_idx, phase <= 0, active <= 1.
- All voices busy: steal voice steal_ptr (overwrite note, phase <= 0), then steal_ptr increments modulo NUM_VOICES.
REQ-024 Accepted note-off clears active for the voice holding note_idx; phase and note are retained; no match = no effect.
REQ-025 Only one voice may hold a given note (guaranteed by the retrigger rule).
REQ-026 tbl_idx = 0 when not in SCAN.

Reset
REQ-027 rst at any time, including mid-SCAN, forces within one cycle:
- state IDLE; voice_active, all phases, notes, steal_ptr, pending and overrun = 0.
- phase_valid, frame_done = 0; note_ready = 1 on the first cycle after rst deasserts.

Structure
REQ-028 Shared package synth_pkg holds PHASE_W = 24, NOTE_W = 7, default NUM_VOICES and the FSM state enum; the frequency-step table and oscillators also use it.
REQ-029 Allocation (free search, match search, steal pointer) lives in one sub-module, voice_alloc; the frequency-step table stays outside this block.

Verification
REQ-030 Note-on 69, then one tick -> phase_valid on voice 0 with phase_out = 167391; second tick -> 334782; frame_done 9 cycles after each tick.
REQ-031 Note-on 127, then 4 ticks -> phases 4772129, 9544258, 14316387, then 2311300 (wrap at 2^24).
REQ-032 Nine distinct note-ons (60..68) with NUM_VOICES = 8 -> note 68 steals voice 0 and steal_ptr becomes 1; note-off 64 clears voice_active[4] only.
REQ-033 sample_tick and note_valid in the same IDLE cycle -> note not accepted (note_ready = 0); a tick during SCAN -> a second scan starts after DONE; two ticks during one SCAN -> overrun = 1.
REQ-034 rst asserted during the SCAN cycle of voice 3 -> next cycle: all outputs zero, voice_active = 0, note_ready = 1 after rst deasserts.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: data widths, default polyphony and the
// scheduler state encoding used by the voice scheduler, table and oscillators.
package synth_pkg;

    localparam int PHASE_W            = 24;
    localparam int NOTE_W             = 7;
    localparam int NUM_VOICES_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/voice_alloc.sv
// Voice allocation: finds the active voice already holding a note, the
// lowest-numbered free voice, and owns the round-robin steal pointer used
// when every voice is busy.
module voice_alloc
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
    parameter int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_VOICES-1:0]               voice_active,
    input  logic [NUM_VOICES-1:0][NOTE_W-1:0]   voice_note,
    input  logic [NOTE_W-1:0]                   note_idx,
    input  logic                                steal_adv,
    output logic                                match_hit,
    output logic [VOICE_W-1:0]                  match_voice,
    output logic                                free_hit,
    output logic [VOICE_W-1:0]                  free_voice,
    output logic [VOICE_W-1:0]                  steal_ptr
);

    // Match search: an active voice holding note_idx (at most one exists);
    // scanning downwards lets the lowest index win if that ever changed.
    always_comb begin
        match_hit   = 1'b0;
        match_voice = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_active[i] && (voice_note[i] == note_idx)) begin
                match_hit   = 1'b1;
                match_voice = VOICE_W'(i);
            end
        end
    end

    // Free search: lowest-numbered inactive voice.
    always_comb begin
        free_hit   = 1'b0;
        free_voice = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!voice_active[i]) begin
                free_hit   = 1'b1;
                free_voice = VOICE_W'(i);
            end
        end
    end

    // Steal pointer advances after each steal; NUM_VOICES is a power of two
    // so the natural counter wrap gives the modulo.
    always_ff @(posedge clk) begin
        if (rst) begin
            steal_ptr <= '0;
        end else if (steal_adv) begin
            steal_ptr <= steal_ptr + VOICE_W'(1);
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: accepts note on/off events while idle, and on
// every sample tick walks all voices once, advancing the phase of each active
// voice by the step looked up in the external frequency table.
module voice_scheduler #(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES_DEFAULT,
    parameter int PHASE_W    = synth_pkg::PHASE_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_tick,
    input  logic                          note_valid,
    output logic                          note_ready,
    input  logic                          note_on,
    input  logic [synth_pkg::NOTE_W-1:0]  note_idx,
    output logic [synth_pkg::NOTE_W-1:0]  tbl_idx,
    input  logic [PHASE_W-1:0]            tbl_step,
    output logic                          phase_valid,
    output logic [$clog2(NUM_VOICES)-1:0] phase_voice,
    output logic [PHASE_W-1:0]            phase_out,
    output logic                          frame_done,
    output logic [NUM_VOICES-1:0]         voice_active,
    output logic                          overrun
);

    import synth_pkg::*;

    localparam int                 VOICE_W    = $clog2(NUM_VOICES);
    localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);

    sched_state_t                      state;
    sched_state_t                      next_state;
    logic [VOICE_W-1:0]                voice_cnt;
    logic                              pending;
    logic                              scan_en;
    logic                              accept;
    logic                              steal_adv;
    logic                              emit;
    logic [PHASE_W-1:0]                phase_sum;
    logic [NUM_VOICES-1:0]             active;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] notes;
    logic [PHASE_W-1:0]                phase [NUM_VOICES];
    logic                              match_hit;
    logic [VOICE_W-1:0]                match_voice;
    logic                              free_hit;
    logic [VOICE_W-1:0]                free_voice;
    logic [VOICE_W-1:0]                steal_ptr;

    assign voice_active = active;
    assign accept       = note_valid && note_ready;
    assign steal_adv    = accept && note_on && !match_hit && !free_hit;
    assign phase_sum    = phase[voice_cnt] + tbl_step;
    assign emit         = scan_en && active[voice_cnt];

    voice_alloc #(
        .NUM_VOICES (NUM_VOICES),
        .VOICE_W    (VOICE_W)
    ) u_alloc (
        .clk          (clk),
        .rst          (rst),
        .voice_active (active),
        .voice_note   (notes),
        .note_idx     (note_idx),
        .steal_adv    (steal_adv),
        .match_hit    (match_hit),
        .match_voice  (match_voice),
        .free_hit     (free_hit),
        .free_voice   (free_voice),
        .steal_ptr    (steal_ptr)
    );

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a tick (fresh or pending) starts a scan that ends after the
    // last voice, followed by a single DONE cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_tick || pending) next_state = SCAN;
            SCAN:    if (voice_cnt == LAST_VOICE) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded outputs; ticks win over note events in the same cycle.
    always_comb begin
        scan_en    = (state == SCAN);
        frame_done = (state == DONE);
        note_ready = (state == IDLE) && !sample_tick && !pending;
        tbl_idx    = scan_en ? notes[voice_cnt] : '0;
    end

    // Voice counter walks 0..NUM_VOICES-1 during a scan and rests at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            voice_cnt <= '0;
        end else if (scan_en) begin
            voice_cnt <= voice_cnt + VOICE_W'(1);
        end else begin
            voice_cnt <= '0;
        end
    end

    // Tick bookkeeping: remember one tick that arrives while busy, flag any
    // further tick as lost; a pending tick is consumed when IDLE launches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (state == IDLE) begin
            if (!sample_tick) begin
                pending <= 1'b0;
            end
        end else if (sample_tick) begin
            if (pending) begin
                overrun <= 1'b1;
            end else begin
                pending <= 1'b1;
            end
        end
    end

    // Voice storage: phases advance during a scan; note events (only
    // accepted while idle) retrigger, allocate, steal or release voices.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
            notes  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
            end
        end else if (scan_en) begin
            if (active[voice_cnt]) begin
                phase[voice_cnt] <= phase_sum;
            end
        end else if (accept) begin
            if (note_on) begin
                if (match_hit) begin
                    phase[match_voice] <= '0;
                end else if (free_hit) begin
                    notes[free_voice]  <= note_idx;
                    phase[free_voice]  <= '0;
                    active[free_voice] <= 1'b1;
                end else begin
                    notes[steal_ptr] <= note_idx;
                    phase[steal_ptr] <= '0;
                end
            end else if (match_hit) begin
                active[match_voice] <= 1'b0;
            end
        end
    end

    // Emitted phase is registered one cycle behind its scan slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_valid <= 1'b0;
            phase_voice <= '0;
            phase_out   <= '0;
        end else begin
            phase_valid <= emit;
            if (emit) begin
                phase_voice <= voice_cnt;
                phase_out   <= phase_sum;
            end
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: a behavioural voice model pushes
// expected phase emissions into a scoreboard that a monitor drains.
module tb_voice_scheduler;

    localparam int NV = 8;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_tick = 1'b0;
    logic          note_valid = 1'b0;
    logic          note_ready;
    logic          note_on = 1'b0;
    logic [6:0]    note_idx = '0;
    logic [6:0]    tbl_idx;
    logic [PW-1:0] tbl_step;
    logic          phase_valid;
    logic [2:0]    phase_voice;
    logic [PW-1:0] phase_out;
    logic          frame_done;
    logic [NV-1:0] voice_active;
    logic          overrun;

    int errors = 0;
    int checks = 0;
    int pv_count = 0;
    logic [PW-1:0] last_phase = '0;
    logic [2:0]    last_voice = '0;

    typedef struct {
        logic [2:0]    voice;
        logic [PW-1:0] phase;
    } sb_item_t;

    sb_item_t      sb[$];
    sb_item_t      sb_head;
    bit            m_active[NV];
    logic [6:0]    m_note[NV];
    logic [PW-1:0] m_phase[NV];
    int            m_steal;

    voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_on      (note_on),
        .note_idx     (note_idx),
        .tbl_idx      (tbl_idx),
        .tbl_step     (tbl_step),
        .phase_valid  (phase_valid),
        .phase_voice  (phase_voice),
        .phase_out    (phase_out),
        .frame_done   (frame_done),
        .voice_active (voice_active),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Stand-in frequency-step table; 69 and 127 carry their real 44.1 kHz steps.
    function automatic logic [PW-1:0] step_of(input logic [6:0] n);
        if (n == 7'd69)  return 24'd167391;
        if (n == 7'd127) return 24'd4772129;
        return PW'((int'(n) + 1) * 1000 + 7);
    endfunction

    assign tbl_step = step_of(tbl_idx);

    // Scoreboard monitor: every phase emission must match the next expectation.
    always @(negedge clk) begin
        if (phase_valid === 1'b1) begin
            checks++;
            pv_count++;
            last_phase = phase_out;
            last_voice = phase_voice;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected voice=%0d phase=%0d required=none", phase_voice, phase_out);
            end else begin
                sb_head = sb.pop_front();
                if (phase_voice !== sb_head.voice || phase_out !== sb_head.phase) begin
                    errors++;
                    $display("[TB] FAIL sb_phase got voice=%0d phase=%0d required voice=%0d phase=%0d",
                             phase_voice, phase_out, sb_head.voice, sb_head.phase);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 1'b0;
            m_note[i]   = '0;
            m_phase[i]  = '0;
        end
        m_steal = 0;
        sb.delete();
    endtask

    task automatic model_note(input bit on, input logic [6:0] n);
        int hit  = -1;
        int free = -1;
        for (int i = 0; i < NV; i++) begin
            if (m_active[i] && m_note[i] == n) hit = i;
        end
        if (!on) begin
            if (hit >= 0) m_active[hit] = 1'b0;
        end else if (hit >= 0) begin
            m_phase[hit] = '0;
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (!m_active[i] && free < 0) free = i;
            end
            if (free >= 0) begin
                m_active[free] = 1'b1;
                m_note[free]   = n;
                m_phase[free]  = '0;
            end else begin
                m_note[m_steal]  = n;
                m_phase[m_steal] = '0;
                m_steal          = (m_steal + 1) % NV;
            end
        end
    endtask

    task automatic model_scan();
        for (int v = 0; v < NV; v++) begin
            if (m_active[v]) begin
                m_phase[v] = m_phase[v] + step_of(m_note[v]);
                sb.push_back('{voice: 3'(v), phase: m_phase[v]});
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (note_ready !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
    endtask

    task automatic send_note(input bit on, input logic [6:0] n);
        wait_idle();
        note_valid = 1'b1;
        note_on    = on;
        note_idx   = n;
        model_note(on, n);
        cyc();
        note_valid = 1'b0;
    endtask

    task automatic do_tick(output int lat);
        wait_idle();
        sample_tick = 1'b1;
        model_scan();
        cyc();
        sample_tick = 1'b0;
        lat = 1;
        while (frame_done !== 1'b1 && lat < 40) begin
            cyc();
            lat++;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        sample_tick = 1'b0;
        note_valid  = 1'b0;
        cyc();
        cyc();
        model_reset();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        checks++; if (voice_active !== '0) begin errors++; $display("[TB] FAIL rst_active got=%0h required=0", voice_active); end
        checks++; if (phase_valid !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_strobes got=%0b%0b required=00", phase_valid, frame_done); end
        checks++; if (overrun !== 1'b0 || tbl_idx !== '0) begin errors++; $display("[TB] FAIL rst_misc got overrun=%0b tbl_idx=%0d required 0/0", overrun, tbl_idx); end
        model_reset();
        rst = 1'b0;
        #1;
        checks++; if (note_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got=%0b required=1", note_ready); end
    endtask

    task automatic test_basic();
        int lat;
        do_reset();
        send_note(1'b1, 7'd69);
        checks++; if (voice_active !== 8'h01) begin errors++; $display("[TB] FAIL basic_active got=%0h required=01", voice_active); end
        do_tick(lat);
        checks++; if (lat != 9) begin errors++; $display("[TB] FAIL basic_latency1 got=%0d required=9", lat); end
        checks++; if (last_phase !== 24'd167391 || last_voice !== 3'd0) begin errors++; $display("[TB] FAIL basic_phase1 got=%0d v%0d required=167391 v0", last_phase, last_voice); end
        do_tick(lat);
        checks++; if (lat != 9) begin errors++; $display("[TB] FAIL basic_latency2 got=%0d required=9", lat); end
        checks++; if (last_phase !== 24'd334782) begin errors++; $display("[TB] FAIL basic_phase2 got=%0d required=334782", last_phase); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [PW-1:0] exp_ph[4];
        exp_ph = '{24'd4772129, 24'd9544258, 24'd14316387, 24'd2311300};
        do_reset();
        send_note(1'b1, 7'd127);
        for (int k = 0; k < 4; k++) begin
            do_tick(lat);
            checks++; if (last_phase !== exp_ph[k]) begin errors++; $display("[TB] FAIL wrap_phase%0d got=%0d required=%0d", k, last_phase, exp_ph[k]); end
        end
    endtask

    task automatic test_steal();
        int lat;
        do_reset();
        for (int n = 60; n <= 68; n++) send_note(1'b1, 7'(n));
        checks++; if (voice_active !== 8'hFF) begin errors++; $display("[TB] FAIL steal_full got=%0h required=ff", voice_active); end
        do_tick(lat);
        send_note(1'b1, 7'd70);
        do_tick(lat);
        send_note(1'b1, 7'd65);
        do_tick(lat);
        send_note(1'b0, 7'd64);
        checks++; if (voice_active !== 8'hEF) begin errors++; $display("[TB] FAIL steal_noteoff got=%0h required=ef", voice_active); end
        send_note(1'b0, 7'd99);
        checks++; if (voice_active !== 8'hEF) begin errors++; $display("[TB] FAIL steal_nomatch got=%0h required=ef", voice_active); end
        send_note(1'b1, 7'd64);
        checks++; if (voice_active !== 8'hFF) begin errors++; $display("[TB] FAIL steal_refill got=%0h required=ff", voice_active); end
        do_tick(lat);
        cyc();
        cyc();
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL steal_sb_left got=%0d required=0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int frames;
        int first_at;
        int second_at;
        do_reset();
        send_note(1'b1, 7'd60);
        wait_idle();
        sample_tick = 1'b1;
        note_valid  = 1'b1;
        note_on     = 1'b1;
        note_idx    = 7'd61;
        model_scan();
        #1;
        checks++; if (note_ready !== 1'b0) begin errors++; $display("[TB] FAIL prio_ready got=%0b required=0", note_ready); end
        cyc();
        sample_tick = 1'b0;
        note_valid  = 1'b0;
        lat = 1;
        while (frame_done !== 1'b1 && lat < 40) begin cyc(); lat++; end
        checks++; if (voice_active !== 8'h01) begin errors++; $display("[TB] FAIL prio_active got=%0h required=01", voice_active); end

        wait_idle();
        sample_tick = 1'b1; model_scan(); cyc(); sample_tick = 1'b0;
        cyc(); cyc();
        sample_tick = 1'b1; model_scan(); cyc(); sample_tick = 1'b0;
        frames = 0; first_at = -1; second_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (frame_done === 1'b1) begin
                frames++;
                if (first_at < 0) first_at = i; else second_at = i;
            end
            cyc();
        end
        checks++; if (frames != 2) begin errors++; $display("[TB] FAIL pend_frames got=%0d required=2", frames); end
        checks++; if (second_at - first_at != 10) begin errors++; $display("[TB] FAIL pend_gap got=%0d required=10", second_at - first_at); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL pend_overrun got=%0b required=0", overrun); end

        wait_idle();
        sample_tick = 1'b1; model_scan(); cyc(); sample_tick = 1'b0;
        cyc();
        sample_tick = 1'b1; model_scan(); cyc(); sample_tick = 1'b0;
        cyc();
        sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
        for (int i = 0; i < 40; i++) cyc();
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag got=%0b required=1", overrun); end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL ovr_sb_left got=%0d required=0", sb.size()); end
    endtask

    task automatic test_reset_midscan();
        int lat;
        int pv_before;
        do_reset();
        for (int n = 60; n <= 63; n++) send_note(1'b1, 7'(n));
        wait_idle();
        sample_tick = 1'b1;
        model_scan();
        cyc();
        sample_tick = 1'b0;
        cyc(); cyc(); cyc();
        checks++; if (tbl_idx !== 7'd63) begin errors++; $display("[TB] FAIL mid_tbl_idx got=%0d required=63", tbl_idx); end
        rst = 1'b1;
        cyc();
        checks++; if (phase_valid !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL mid_strobes got=%0b%0b%0b required=000", phase_valid, frame_done, overrun); end
        checks++; if (voice_active !== '0 || tbl_idx !== '0 || phase_out !== '0) begin errors++; $display("[TB] FAIL mid_state got act=%0h tbl=%0d ph=%0d required 0/0/0", voice_active, tbl_idx, phase_out); end
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (note_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got=%0b required=1", note_ready); end
        pv_before = pv_count;
        do_tick(lat);
        cyc();
        checks++; if (lat != 9 || pv_count != pv_before) begin errors++; $display("[TB] FAIL mid_empty_scan got lat=%0d emits=%0d required 9/0", lat, pv_count - pv_before); end
        send_note(1'b1, 7'd69);
        do_tick(lat);
        checks++; if (last_phase !== 24'd167391) begin errors++; $display("[TB] FAIL mid_restart got=%0d required=167391", last_phase); end
    endtask

    // Test sequence.
    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_wrap();
        test_steal();
        test_back_to_back();
        test_reset_midscan();
        cyc();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
